// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 7-segment scanner with blanking, brightness PWM and frame strobe
module seg_scan #(
    parameter int NUM_SEG     = 6,
    parameter int CLK_HZ      = 50000000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLANK_CYC   = 16,
    parameter int DIG_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_SEG-1:0]   seg_in,
    input  logic                   en,
    input  logic [3:0]             bright,
    output logic [NUM_SEG-1:0]     dig_out,
    output logic [7:0]             seg_out,
    output logic                   frame_tick
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

    localparam logic [NUM_SEG-1:0] DIG_OFF  = {NUM_SEG{DIG_ACT_LOW != 0}};
    localparam logic [7:0]         SEG_OFF  = {8{SEG_ACT_LOW != 0}};
    localparam logic [CW-1:0]      CNT_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_SEG - 1);

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [7:0]         seg_lat;
    logic [3:0]         bri_lat;

    logic [7:0]         seg_sel;
    logic [NUM_SEG-1:0] onehot;
    logic [7:0]         seg_cur;
    logic [3:0]         bri_cur;
    logic [31:0]        on_cyc;
    logic [31:0]        cnt32;
    logic               cnt_last;
    logic               lit;

    // Select the current digit's pattern and build its one-hot enable
    always_comb begin
        seg_sel = 8'h00;
        onehot  = '0;
        for (int j = 0; j < NUM_SEG; j++) begin
            if (idx == IW'(j)) begin
                seg_sel   = seg_in[j*8 +: 8];
                onehot[j] = 1'b1;
            end
        end
    end

    // Slot window: blank phase, then an on-window scaled by the latched brightness.
    // At cnt==0 the snapshot is being taken, so use the live values that cycle.
    always_comb begin
        cnt_last = (cnt == CNT_LAST);
        seg_cur  = (cnt == '0) ? seg_sel : seg_lat;
        bri_cur  = (cnt == '0) ? bright  : bri_lat;
        on_cyc   = (32'(DWELL - BLANK_CYC) * (32'(bri_cur) + 32'd1)) >> 4;
        cnt32    = 32'(cnt);
        lit      = (cnt32 >= 32'(BLANK_CYC)) && ((cnt32 - 32'(BLANK_CYC)) < on_cyc);
    end

    // Slot counter, digit index, snapshot latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            seg_lat    <= 8'h00;
            bri_lat    <= 4'h0;
            dig_out    <= DIG_OFF;
            seg_out    <= SEG_OFF;
            frame_tick <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            idx        <= '0;
            dig_out    <= DIG_OFF;
            seg_out    <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == '0) begin
                seg_lat <= seg_sel;
                bri_lat <= bright;
            end
            if (cnt_last) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            frame_tick <= cnt_last && (idx == IDX_LAST);
            if (lit) begin
                dig_out <= onehot ^ DIG_OFF;
                seg_out <= seg_cur ^ SEG_OFF;
            end else begin
                dig_out <= DIG_OFF;
                seg_out <= SEG_OFF;
            end
        end
    end

endmodule
